mult_div_unit: RTL and testbench
================================

# mult_div_unit

Parametrised iterative multiply/divide unit that produces the HI/LO result pair for MULT, MULTU, DIV and DIVU. It replaces the separate multiplier and divider blocks next to the CPU datapath's HI/LO registers with one shared engine. The engine has a common start/ready handshake and a selectable operation mode. It adds unsigned modes, operand latching, a busy indication and single-cycle divide-by-zero detection, none of which the separate blocks provide.

## Interface
- WIDTH, 32: operand width; hi/lo are each WIDTH bits; must be ≥ 4.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- start  in  1  request; sampled only in IDLE.
- op  in  2  operation, sampled with start: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- a  in  WIDTH  multiplicand / dividend; sampled with start.
- b  in  WIDTH  multiplier / divisor; sampled with start.
- hi  out  WIDTH  multiply: upper product half; divide: remainder.
- lo  out  WIDTH  multiply: lower product half; divide: quotient.
- busy  out  1  high while an operation is in progress (state ≠ IDLE).
- ready  out  1  one-cycle completion pulse.
- div_zero  out  1  one-cycle pulse, coincident with ready, for DIV/DIVU with b = 0.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1 and divide with b=0:
  - go to DONE with a zero flag set; no iterations are performed.
- IDLE, start=1 otherwise:
  - latch op;
  - latch |a| and |b| for signed ops, raw values for unsigned ops;
  - latch result sign flags;
  - load iteration counter = WIDTH;
  - go to RUN.
- RUN: one iteration per cycle; counter decrements; go to DONE after the WIDTH-th iteration.
  - multiply: shift-add on a 2·WIDTH-bit accumulator.
  - divide: restoring division, one quotient bit per cycle.
- DONE: apply sign correction, register hi/lo, pulse ready; go to IDLE.
  - zero flag set: hi/lo unchanged, ready=1 and div_zero=1.
- Arithmetic rules:
  - MULT: full 2·WIDTH two's-complement product.
  - MULTU: full unsigned product.
  - DIV: quotient truncates toward zero; remainder takes the dividend's sign; |remainder| < |divisor|.
  - DIV of MIN_INT by −1: lo = MIN_INT (wraps), hi = 0; no flag.
  - DIVU: plain unsigned quotient and remainder.
- start while busy: ignored; no queueing.
- a, b and op changing after the start sample: no effect on the running operation.
- hi/lo hold their value until the next successful completion; a div-by-zero completion does not alter them.
- reset asserted at any time, including mid-operation: aborts asynchronously to IDLE.

## Timing
- Reset values:
  - hi = 0, lo = 0;
  - busy = 0, ready = 0, div_zero = 0;
  - state = IDLE, counter = 0.
- Normal operation (edge E0 samples start):
  - busy is high from after E0 through the cycle before E(WIDTH+1).
  - hi/lo update and ready=1 at E(WIDTH+1).
  - ready drops at E(WIDTH+2).
  - Latency = WIDTH+1 clocks; 33 for WIDTH=32.
- Divide by zero: ready=div_zero=1 at E2, hi/lo unchanged; latency 2 clocks.
- Back-to-back: start may be asserted in the same cycle that ready is high, because state is IDLE then. The new operation is sampled at that edge.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset, then MULT a=0xFFFFFFFD (−3), b=7 → after 33 edges hi=0xFFFFFFFF, lo=0xFFFFFFEB; ready high exactly 1 cycle; busy high for 33 cycles.
- MULTU a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=−7, b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIVU a=100, b=7 → lo=14, hi=2. DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- DIV a=5, b=0 with prior hi=0x11, lo=0x22 → ready and div_zero pulse 2 clocks after start; hi=0x11, lo=0x22 retained; busy low afterward.
- Start MULT, pulse start with different a/b/op at cycle 10 → the second request is ignored; the result matches the first request; ready pulses once.
- Drive reset low at cycle 15 of a DIVU → busy=ready=0 and hi=lo=0 immediately. After release, a fresh DIVU 9/3 gives lo=3, hi=0 in 33 clocks.

Source files
------------

// File: rtl/mult_div_unit.sv
// Shared iterative multiply/divide engine producing the HI/LO pair.
// Shift-add multiply and restoring divide, one step per clock.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             ready,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 div_q, div_d;
    logic                 zero_q, zero_d;
    logic                 neg_lo_q, neg_lo_d;
    logic                 neg_hi_q, neg_hi_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     opb_q, opb_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 busy_q, busy_d;
    logic                 ready_q, ready_d;
    logic                 dz_q, dz_d;

    logic                 a_neg, b_neg;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       div_try;
    logic [WIDTH:0]       div_diff;
    logic                 div_ge;
    logic [2*WIDTH-1:0]   div_next;
    logic [2*WIDTH-1:0]   prod;
    logic [WIDTH-1:0]     quo;
    logic [WIDTH-1:0]     rem;

    // Operand magnitudes; op[0] selects the unsigned variants.
    always_comb begin
        a_neg = ~op[0] & a[WIDTH-1];
        b_neg = ~op[0] & b[WIDTH-1];
        a_mag = a_neg ? -a : a;
        b_mag = b_neg ? -b : b;
    end

    // acc holds {upper product, multiplier} or {remainder, dividend/quotient}.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                 + (acc_q[0] ? {1'b0, opb_q} : '0);
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};

        div_try  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff = div_try - {1'b0, opb_q};
        div_ge   = (div_try >= {1'b0, opb_q});
        div_next = div_ge
                 ? {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1}
                 : {div_try[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};

        prod = neg_lo_q ? -acc_q : acc_q;
        quo  = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem  = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH]
                        : acc_q[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        div_d    = div_q;
        zero_d   = zero_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        ready_d  = 1'b0;
        dz_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    div_d = op[1];
                    if (op[1] && (b == '0)) begin
                        // One holding cycle in DONE gives a 2-clock latency.
                        zero_d  = 1'b1;
                        cnt_d   = CW'(1);
                        state_d = DONE;
                    end else begin
                        zero_d   = 1'b0;
                        acc_d    = {{WIDTH{1'b0}}, a_mag};
                        opb_d    = b_mag;
                        neg_lo_d = a_neg ^ b_neg;
                        neg_hi_d = a_neg;
                        cnt_d    = CW'(WIDTH);
                        state_d  = RUN;
                    end
                end
            end
            RUN: begin
                acc_d = div_q ? div_next : mul_next;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                    if (zero_q) begin
                        dz_d = 1'b1;
                    end else if (div_q) begin
                        hi_d = rem;
                        lo_d = quo;
                    end else begin
                        hi_d = prod[2*WIDTH-1:WIDTH];
                        lo_d = prod[WIDTH-1:0];
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            div_q    <= 1'b0;
            zero_q   <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            acc_q    <= '0;
            opb_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            zero_q   <= zero_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            ready_q  <= ready_d;
            dz_q     <= dz_d;
        end
    end

    assign hi       = hi_q;
    assign lo       = lo_q;
    assign busy     = busy_q;
    assign ready    = ready_q;
    assign div_zero = dz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed and randomised checks of mult_div_unit against a scoreboard.
// Expected HI/LO results are queued at issue and popped on ready.
module tb_mult_div_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         busy;
    logic         ready;
    logic         div_zero;

    typedef struct {
        string        tag;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           lat;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .hi       (hi),
        .lo       (lo),
        .busy     (busy),
        .ready    (ready),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [1:0] o,
                                          input logic [W-1:0] x,
                                          input logic [W-1:0] y);
        longint p;
        int     q;
        int     r;
        case (o)
            2'b00: begin
                p = longint'($signed(x)) * longint'($signed(y));
                return p;
            end
            2'b01: return {32'h0, x} * {32'h0, y};
            2'b10: begin
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
                    return {32'h0, 32'h8000_0000};
                q = $signed(x) / $signed(y);
                r = $signed(x) % $signed(y);
                return {r, q};
            end
            default: return {x % y, x / y};
        endcase
    endfunction

    // Issue one request, wait for ready, compare against the queued result.
    // glitch >= 0 re-asserts start with other operands that many edges in.
    task automatic run_op(input string tag, input logic [1:0] o,
                          input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W-1:0] ehi, input logic [W-1:0] elo,
                          input logic edz, input int elat, input int glitch);
        exp_t e;
        int   n;
        int   bc;
        sb.push_back('{tag, ehi, elo, edz, elat});
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        n  = 0;
        bc = busy ? 1 : 0;
        while (!ready && n < 60) begin
            if (n == glitch) begin
                start = 1'b1;
                op    = ~o;
                a     = ~x;
                b     = y + 32'd5;
            end else begin
                op = 2'($urandom);
                a  = $urandom;
                b  = $urandom;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            n++;
            if (busy) bc++;
        end
        e = sb.pop_front();
        chk({e.tag, " ready"}, 64'(ready), 64'(1));
        chk({e.tag, " latency"}, 64'(n), 64'(e.lat));
        chk({e.tag, " busy_cycles"}, 64'(bc), 64'(e.lat));
        chk({e.tag, " hi"}, 64'(hi), 64'(e.hi));
        chk({e.tag, " lo"}, 64'(lo), 64'(e.lo));
        chk({e.tag, " div_zero"}, 64'(div_zero), 64'(e.dz));
        @(posedge clk);
        #1;
        chk({e.tag, " ready_drop"}, 64'(ready), 64'(0));
        chk({e.tag, " dz_drop"}, 64'(div_zero), 64'(0));
        chk({e.tag, " busy_after"}, 64'(busy), 64'(0));
        chk({e.tag, " hi_hold"}, 64'(hi), 64'(e.hi));
        chk({e.tag, " lo_hold"}, 64'(lo), 64'(e.lo));
    endtask

    initial begin
        logic [63:0]  m;
        logic [1:0]   ro;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        int           extra;

        reset = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        #12;
        chk("rst hi", 64'(hi), 64'(0));
        chk("rst lo", 64'(lo), 64'(0));
        chk("rst busy", 64'(busy), 64'(0));
        chk("rst ready", 64'(ready), 64'(0));
        chk("rst dz", 64'(div_zero), 64'(0));
        @(negedge clk);
        reset = 1'b1;

        run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd7,
               32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 33, -1);
        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 33, -1);
        run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2,
               32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33, -1);
        run_op("divu", 2'b11, 32'd100, 32'd7,
               32'd2, 32'd14, 1'b0, 33, -1);
        run_op("div_minint", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF,
               32'h0, 32'h8000_0000, 1'b0, 33, -1);

        run_op("ignore_start", 2'b00, 32'd6, 32'hFFFF_FFFC,
               32'hFFFF_FFFF, 32'hFFFF_FFE8, 1'b0, 33, 10);
        extra = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (ready) extra++;
        end
        chk("ignore_start extra_ready", 64'(extra), 64'(0));

        for (int i = 0; i < 8; i++) begin
            ro = 2'(i);
            ra = $urandom;
            rb = $urandom;
            if (i % 3 == 0) rb = rb >> 20;
            if (ro[1] && rb == '0) rb = 32'd3;
            m = model(ro, ra, rb);
            run_op($sformatf("rand%0d", i), ro, ra, rb,
                   m[63:32], m[31:0], 1'b0, 33, -1);
        end

        run_op("divu_setup", 2'b11, 32'h2211, 32'h100,
               32'h11, 32'h22, 1'b0, 33, -1);
        run_op("div_zero", 2'b10, 32'd5, 32'd0,
               32'h11, 32'h22, 1'b1, 2, -1);

        @(negedge clk);
        start = 1'b1;
        op    = 2'b11;
        a     = 32'd1000;
        b     = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        chk("abort busy_before", 64'(busy), 64'(1));
        reset = 1'b0;
        #1;
        chk("abort busy", 64'(busy), 64'(0));
        chk("abort ready", 64'(ready), 64'(0));
        chk("abort hi", 64'(hi), 64'(0));
        chk("abort lo", 64'(lo), 64'(0));
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("abort idle", 64'(busy), 64'(0));
        run_op("divu_after_rst", 2'b11, 32'd9, 32'd3,
               32'd0, 32'd3, 1'b0, 33, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
